dcf77_encoder: RTL and testbench
================================

Name: dcf77_encoder

Overview:
DCF77 time-code generator, the transmit-side counterpart of the clock's bit_sampler/decoder/time_date_decoder chain. It takes BCD time/date fields and emits one 60-second DCF77 amplitude-modulation frame per minute as a baseband level on a single output pin. The output is intended to drive a test transmitter or to loop back into the receiver's data input for self-test.

Parameters:
CLK_FREQ, 12500, clk_i cycles per second; must be a multiple of 10.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous, active-low reset
load_i  in  1  one-cycle strobe; captures all *_i fields below into staging
year_h_i, year_l_i  in  4,4  BCD year 00-99
month_h_i, month_l_i  in  1,4  BCD month
day_h_i, day_l_i  in  2,4  BCD day
dow_i  in  3  day of week, 1-7
hour_h_i, hour_l_i  in  2,4  BCD hour
minute_h_i, minute_l_i  in  3,4  BCD minute
cest_i  in  1  summer time flag; drives bit 17 = cest_i and bit 18 = ~cest_i
inverted_i  in  1  XORed combinationally onto data_o
data_o  out  1  carrier level; 1 = full amplitude, 0 = reduced
busy_o  out  1  frame transmission active
bit_idx_o  out  6  index of the second currently being sent, 0-59
frame_start_o  out  1  one-cycle pulse on the first cycle of bit 0

Behaviour:
- Reset: internal data register = 1, busy_o = 0, bit_idx_o = 0, frame_start_o = 0, staging invalid, cycle counter = 0.
- States: IDLE and SEND.
- IDLE:
  - data register holds 1.
  - On load_i, go to SEND on the next cycle with bit_idx_o = 0 and frame_start_o = 1.
- SEND:
  - cycle counter runs 0..CLK_FREQ-1; bit_idx_o increments when the counter wraps.
  - For bit n < 59: data register = 0 for counter < CLK_FREQ/10 if the bit is 0, or counter < CLK_FREQ/5 if the bit is 1; otherwise 1.
  - Bit 59: no reduction (minute marker).
- Frame layout, fields LSB first:
  - bits 0-16: 0
  - bit 17: cest; bit 18: ~cest; bit 19: 0; bit 20: 1
  - bits 21-27: minute (low nibble, then 3 high bits); bit 28: even parity over 21-27
  - bits 29-34: hour; bit 35: even parity over 29-34
  - bits 36-41: day; bits 42-44: dow; bits 45-49: month; bits 50-57: year; bit 58: even parity over 36-57
- Frame boundary: last cycle of bit 59.
  - If staging is valid, the active frame copies staging and staging is cleared.
  - Otherwise the frame is repeated unchanged (see Optional Feature).
  - The FSM stays in SEND; bit_idx_o returns to 0 and frame_start_o pulses.
- load_i mid-frame: fields are only staged; the active frame is not disturbed.
- load_i on the boundary cycle: bypasses staging, so the new fields go into the starting frame.
- A second load_i before the boundary overwrites staging (last write wins).
- Inputs are not range-checked; invalid BCD is transmitted verbatim.
- data_o = data register ^ inverted_i.
- Latency: data_o is registered, one cycle behind the counter state.
- Reset asserted mid-frame: immediate return to IDLE, data register = 1, staging lost.

Optional Feature:
DCF77_ENC_AUTO_INC_EN
- Defined: at a boundary with no valid staging, the active minute increments in BCD.
  - x9 -> (x+1)0; 59 -> 00 with hour increment; hour 23 -> 00.
  - Date fields are never advanced.
- Undefined: the frame repeats unchanged.

Decomposition:
- dcf77_pkg:
  - bit-position localparams: CEST_BIT=17, START_BIT=20, MIN_LSB=21, P1_BIT=28, HOUR_LSB=29, P2_BIT=35, DATE_LSB=36, P3_BIT=58, MARKER_BIT=59
  - packed struct dcf77_time_t for the field set
- Sub-module dcf77_frame_builder: combinational dcf77_time_t + cest to a 59-bit frame vector with parity. The FSM indexes that vector.

Test Plan:
All scenarios use CLK_FREQ=100, so 0-bits are 10 cycles low and 1-bits are 20 cycles low.
1. Reset, no load -> data_o = 1 and busy_o = 0 indefinitely; with inverted_i = 1, data_o = 0.
2. Load 14:37, 2023-05-17 dow 3, cest = 1 -> bits 21-27 = 1110110, P1 = 1; bits 29-34 = 001010, P2 = 0; bit 17 = 1, bit 18 = 0; bit 20 = 20-cycle low; bit 59 = no low; frame is 6000 cycles.
3. Load 12:00 mid-frame at bit 30 -> current frame unchanged; next frame, starting at cycle 6000 after frame_start_o, carries 12:00.
4. Load on the boundary cycle -> the starting frame already carries the new fields.
5. With DCF77_ENC_AUTO_INC_EN, load 23:59 -> second frame encodes 00:00 with P1 = P2 = 0 and the date unchanged; without the macro -> 23:59 repeats.
6. Deassert rst_ni at bit 25 mid-pulse -> data_o = 1, busy_o = 0 asynchronously; next load_i restarts at bit 0.

Source files
------------

// File: rtl/dcf77_pkg.sv
// Shared types, frame bit positions and helpers for the DCF77 time-code encoder.
// DCF77_ENC_AUTO_INC_EN (see dcf77_encoder.sv) makes use of bcd_inc_time.
package dcf77_pkg;

  localparam logic [5:0] CEST_BIT   = 6'd17;
  localparam logic [5:0] START_BIT  = 6'd20;
  localparam logic [5:0] MIN_LSB    = 6'd21;
  localparam logic [5:0] P1_BIT     = 6'd28;
  localparam logic [5:0] HOUR_LSB   = 6'd29;
  localparam logic [5:0] P2_BIT     = 6'd35;
  localparam logic [5:0] DATE_LSB   = 6'd36;
  localparam logic [5:0] P3_BIT     = 6'd58;
  localparam logic [5:0] MARKER_BIT = 6'd59;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dcf77_state_e;

  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic [0:0] month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } dcf77_time_t;

  function automatic logic even_parity(input logic [21:0] v);
    return ^v;
  endfunction

  // Advance minute by one in BCD, carrying into the hour; the date never moves.
  function automatic dcf77_time_t bcd_inc_time(input dcf77_time_t t);
    dcf77_time_t r;
    r = t;
    if (t.minute_l == 4'd9) begin
      r.minute_l = 4'd0;
      if (t.minute_h == 3'd5) begin
        r.minute_h = 3'd0;
        if ((t.hour_h == 2'd2) && (t.hour_l == 4'd3)) begin
          r.hour_h = 2'd0;
          r.hour_l = 4'd0;
        end else if (t.hour_l == 4'd9) begin
          r.hour_l = 4'd0;
          r.hour_h = t.hour_h + 2'd1;
        end else begin
          r.hour_l = t.hour_l + 4'd1;
        end
      end else begin
        r.minute_h = t.minute_h + 3'd1;
      end
    end else begin
      r.minute_l = t.minute_l + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcf77_encoder_if.sv
// Field/strobe inputs and carrier/status outputs of the DCF77 encoder.
interface dcf77_encoder_if;
  logic       load_i;
  logic [3:0] year_h_i;
  logic [3:0] year_l_i;
  logic [0:0] month_h_i;
  logic [3:0] month_l_i;
  logic [1:0] day_h_i;
  logic [3:0] day_l_i;
  logic [2:0] dow_i;
  logic [1:0] hour_h_i;
  logic [3:0] hour_l_i;
  logic [2:0] minute_h_i;
  logic [3:0] minute_l_i;
  logic       cest_i;
  logic       inverted_i;
  logic       data_o;
  logic       busy_o;
  logic [5:0] bit_idx_o;
  logic       frame_start_o;

  modport master (
    output load_i, year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
           dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, cest_i, inverted_i,
    input  data_o, busy_o, bit_idx_o, frame_start_o
  );

  modport slave (
    input  load_i, year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
           dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, cest_i, inverted_i,
    output data_o, busy_o, bit_idx_o, frame_start_o
  );
endinterface

// File: rtl/dcf77_frame_builder.sv
// Combinational mapping of time/date fields and CEST flag onto DCF77 bits 0-58.
module dcf77_frame_builder
  import dcf77_pkg::*;
(
  input  dcf77_time_t tm,
  input  logic        cest,
  output logic [58:0] frame
);

  logic [6:0]  minute_s;
  logic [5:0]  hour_s;
  logic [21:0] date_s;

  assign minute_s = {tm.minute_h, tm.minute_l};
  assign hour_s   = {tm.hour_h, tm.hour_l};
  assign date_s   = {tm.year_h, tm.year_l, tm.month_h, tm.month_l, tm.dow, tm.day_h, tm.day_l};

  // Place each field LSB first and append the three even-parity bits.
  always_comb begin
    frame                  = 59'd0;
    frame[CEST_BIT]        = cest;
    frame[CEST_BIT + 6'd1] = ~cest;
    frame[START_BIT]       = 1'b1;
    frame[MIN_LSB +: 7]    = minute_s;
    frame[P1_BIT]          = even_parity({15'd0, minute_s});
    frame[HOUR_LSB +: 6]   = hour_s;
    frame[P2_BIT]          = even_parity({16'd0, hour_s});
    frame[DATE_LSB +: 22]  = date_s;
    frame[P3_BIT]          = even_parity(date_s);
  end

endmodule

// File: rtl/dcf77_encoder.sv
// DCF77 minute-frame generator: one AM-coded bit per CLK_FREQ cycles, 60 bits per frame.
// Optional DCF77_ENC_AUTO_INC_EN advances the minute when a frame repeats without new data.
module dcf77_encoder
  import dcf77_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12500
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  dcf77_encoder_if.slave  bus
);

  localparam int unsigned    CW       = $clog2(CLK_FREQ);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(CLK_FREQ - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  ZERO_LEN = CW'(CLK_FREQ / 10);
  localparam logic [CW-1:0]  ONE_LEN  = CW'(CLK_FREQ / 5);

  dcf77_state_e state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [5:0]    bit_idx_r, bit_idx_s;
  logic          frame_start_r, frame_start_s;
  logic          data_r, data_s;
  dcf77_time_t   active_r, active_s;
  logic          active_cest_r, active_cest_s;
  dcf77_time_t   stage_r, stage_s;
  logic          stage_cest_r, stage_cest_s;
  logic          stage_valid_r, stage_valid_s;
  dcf77_time_t   fields_s;
  logic [58:0]   frame_s;
  logic          wrap_s;
  logic          boundary_s;

  assign fields_s = {bus.year_h_i, bus.year_l_i, bus.month_h_i, bus.month_l_i,
                     bus.day_h_i, bus.day_l_i, bus.dow_i, bus.hour_h_i, bus.hour_l_i,
                     bus.minute_h_i, bus.minute_l_i};

  dcf77_frame_builder u_builder (
    .tm    (active_r),
    .cest  (active_cest_r),
    .frame (frame_s)
  );

  assign wrap_s     = (state_r == ST_SEND) && (cnt_r == CNT_MAX);
  assign boundary_s = wrap_s && (bit_idx_r == MARKER_BIT);

  // Next-state, counters, staging and carrier level.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    bit_idx_s     = bit_idx_r;
    frame_start_s = 1'b0;
    data_s        = 1'b1;
    active_s      = active_r;
    active_cest_s = active_cest_r;
    stage_s       = stage_r;
    stage_cest_s  = stage_cest_r;
    stage_valid_s = stage_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_i) begin
          state_s       = ST_SEND;
          cnt_s         = '0;
          bit_idx_s     = 6'd0;
          frame_start_s = 1'b1;
          active_s      = fields_s;
          active_cest_s = bus.cest_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Reduced amplitude at the start of each second; the marker second stays high.
        if (bit_idx_r == MARKER_BIT) begin
          data_s = 1'b1;
        end else if (frame_s[bit_idx_r]) begin
          data_s = (cnt_r >= ONE_LEN);
        end else begin
          data_s = (cnt_r >= ZERO_LEN);
        end

        if (boundary_s) begin
          cnt_s         = '0;
          bit_idx_s     = 6'd0;
          frame_start_s = 1'b1;
          stage_valid_s = 1'b0;
          if (bus.load_i) begin
            active_s      = fields_s;
            active_cest_s = bus.cest_i;
          end else if (stage_valid_r) begin
            active_s      = stage_r;
            active_cest_s = stage_cest_r;
          end else begin
`ifdef DCF77_ENC_AUTO_INC_EN
            active_s = bcd_inc_time(active_r);
`else
            active_s = active_r;
`endif
          end
        end else begin
          if (wrap_s) begin
            cnt_s     = '0;
            bit_idx_s = bit_idx_r + 6'd1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
          if (bus.load_i) begin
            stage_s       = fields_s;
            stage_cest_s  = bus.cest_i;
            stage_valid_s = 1'b1;
          end else begin
            stage_valid_s = stage_valid_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      bit_idx_r     <= 6'd0;
      frame_start_r <= 1'b0;
      data_r        <= 1'b1;
      active_r      <= '0;
      active_cest_r <= 1'b0;
      stage_r       <= '0;
      stage_cest_r  <= 1'b0;
      stage_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      bit_idx_r     <= bit_idx_s;
      frame_start_r <= frame_start_s;
      data_r        <= data_s;
      active_r      <= active_s;
      active_cest_r <= active_cest_s;
      stage_r       <= stage_s;
      stage_cest_r  <= stage_cest_s;
      stage_valid_r <= stage_valid_s;
    end
  end

  assign bus.data_o        = data_r ^ bus.inverted_i;
  assign bus.busy_o        = (state_r == ST_SEND);
  assign bus.bit_idx_o     = bit_idx_r;
  assign bus.frame_start_o = frame_start_r;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Directed bench for dcf77_encoder at CLK_FREQ=100: measures per-second low time of each frame.
`timescale 1ns/1ps
module tb_dcf77_encoder;

  localparam logic [21:0] DATE = {8'h23, 5'h05, 3'd3, 6'h17};  // 2023-05-17, dow 3, parity 1

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dcf77_encoder_if bus ();

  dcf77_encoder #(.CLK_FREQ(100)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] exp_frame(input logic [6:0] minute, input logic p1,
                                            input logic [5:0] hour, input logic p2,
                                            input logic cest);
    return {1'b0, 1'b1, DATE, p2, hour, p1, minute, 1'b1, 1'b0, ~cest, cest, 17'd0};
  endfunction

  task automatic set_fields(input logic [5:0] hour, input logic [6:0] minute, input logic cest);
    bus.year_h_i   = DATE[21:18];
    bus.year_l_i   = DATE[17:14];
    bus.month_h_i  = DATE[13];
    bus.month_l_i  = DATE[12:9];
    bus.dow_i      = DATE[8:6];
    bus.day_h_i    = DATE[5:4];
    bus.day_l_i    = DATE[3:0];
    bus.hour_h_i   = hour[5:4];
    bus.hour_l_i   = hour[3:0];
    bus.minute_h_i = minute[6:4];
    bus.minute_l_i = minute[3:0];
    bus.cest_i     = cest;
  endtask

  // Enter at a negedge where frame_start_o should be high; optionally strobe load_i at one cycle.
  task automatic capture_frame(input string name, input logic [59:0] exp, input int load_at);
    int low_cnt [60];
    int exp_low;
    foreach (low_cnt[i]) low_cnt[i] = 0;
    checks++;
    if (bus.frame_start_o !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start got %b want 1", name, bus.frame_start_o);
    end
    for (int k = 0; k < 6000; k++) begin
      bus.load_i = (k == load_at);
      if (bus.data_o == 1'b0) low_cnt[k / 100]++;
      if ((k % 100) == 0) begin
        checks++;
        if ((bus.bit_idx_o !== 6'(k / 100)) || (bus.busy_o !== 1'b1)) begin
          errors++;
          $display("FAIL %s bit_idx/busy got %0d/%b want %0d/1", name, bus.bit_idx_o,
                   bus.busy_o, k / 100);
        end
      end
      @(negedge clk);
    end
    bus.load_i = 1'b0;
    for (int n = 0; n < 60; n++) begin
      exp_low = (n == 59) ? 0 : (exp[n] ? 20 : 10);
      checks++;
      if (low_cnt[n] != exp_low) begin
        errors++;
        $display("FAIL %s bit%0d low_cycles got %0d want %0d", name, n, low_cnt[n], exp_low);
      end
    end
    checks++;
    if (bus.frame_start_o !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_len next frame_start got %b want 1 at 6000", name, bus.frame_start_o);
    end
  endtask

  task automatic start_from_idle();
    bus.load_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_i = 1'b0;
    bus.inverted_i = 1'b0;
    set_fields(6'h00, 7'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        checks++;
        if ({bus.data_o, bus.busy_o, bus.bit_idx_o, bus.frame_start_o} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
          errors++;
          $display("FAIL reset_idle data/busy/idx/fs got %b/%b/%0d/%b want 1/0/0/0",
                   bus.data_o, bus.busy_o, bus.bit_idx_o, bus.frame_start_o);
        end
      end
    end
    bus.inverted_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.data_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_inverted data_o got %b want 0", bus.data_o);
    end
    bus.inverted_i = 1'b0;
    @(negedge clk);
  endtask

  // 14:37 CEST; 12:00 is staged at bit 30 and must not disturb this frame.
  task automatic test_frame_and_mid_load();
    set_fields(6'h14, 7'h37, 1'b1);
    start_from_idle();
    set_fields(6'h12, 7'h00, 1'b1);
    capture_frame("frame_1437", exp_frame(7'h37, 1'b1, 6'h14, 1'b0, 1'b1), 3005);
  endtask

  task automatic test_next_frame();
    capture_frame("staged_1200", exp_frame(7'h00, 1'b0, 6'h12, 1'b0, 1'b1), -1);
  endtask

  // 08:15 loaded on the boundary cycle goes straight into the following frame.
  task automatic test_boundary_load();
    set_fields(6'h08, 7'h15, 1'b0);
`ifdef DCF77_ENC_AUTO_INC_EN
    capture_frame("repeat_1201", exp_frame(7'h01, 1'b1, 6'h12, 1'b0, 1'b1), 5999);
`else
    capture_frame("repeat_1200", exp_frame(7'h00, 1'b0, 6'h12, 1'b0, 1'b1), 5999);
`endif
    capture_frame("bypass_0815", exp_frame(7'h15, 1'b1, 6'h08, 1'b1, 1'b0), -1);
  endtask

  task automatic test_auto_inc();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_fields(6'h23, 7'h59, 1'b0);
    start_from_idle();
    capture_frame("frame_2359", exp_frame(7'h59, 1'b0, 6'h23, 1'b1, 1'b0), -1);
`ifdef DCF77_ENC_AUTO_INC_EN
    capture_frame("inc_0000", exp_frame(7'h00, 1'b0, 6'h00, 1'b0, 1'b0), -1);
`else
    capture_frame("repeat_2359", exp_frame(7'h59, 1'b0, 6'h23, 1'b1, 1'b0), -1);
`endif
  endtask

  task automatic test_reset_mid_frame();
    repeat (2505) @(negedge clk);
    checks++;
    if ((bus.data_o !== 1'b0) || (bus.bit_idx_o !== 6'd25)) begin
      errors++;
      $display("FAIL pre_reset data/idx got %b/%0d want 0/25", bus.data_o, bus.bit_idx_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.data_o, bus.busy_o, bus.bit_idx_o} !== {1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL async_reset data/busy/idx got %b/%b/%0d want 1/0/0",
               bus.data_o, bus.busy_o, bus.bit_idx_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus.data_o, bus.busy_o} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_idle data/busy got %b/%b want 1/0", bus.data_o, bus.busy_o);
    end
    set_fields(6'h14, 7'h37, 1'b1);
    start_from_idle();
    capture_frame("restart_1437", exp_frame(7'h37, 1'b1, 6'h14, 1'b0, 1'b1), -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_frame_and_mid_load();
    test_next_frame();
    test_boundary_load();
    test_auto_inc();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
